// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared types and constants for the 4-bit CPU control sequencer.
//   opcode_t : instruction opcodes (upper nibble of the instruction byte)
//   state_t  : sequencer states
//   ctrl_t   : one-hot control bundle produced by the instruction decoder
//   ALU_*    : {alu_sel, alu_cin} encodings understood by reg_alu4
package cpu_ctrl_fsm_pkg;

  localparam int unsigned DATA_W  = 4;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned INSTR_W = 8;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'h0,
    OP_LDA  = 4'h1,
    OP_LDB  = 4'h2,
    OP_ALU  = 4'h3,
    OP_MOVB = 4'h4,
    OP_JMP  = 4'h5,
    OP_JZ   = 4'h6,
    OP_JC   = 4'h7,
    OP_OUT  = 4'h8,
    OP_HLT  = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_OUT    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // At most one bit set; all-zero means NOP (including 0x9-0xE)
  typedef struct packed {
    logic lda;
    logic ldb;
    logic alu;
    logic movb;
    logic jmp;
    logic jz;
    logic jc;
    logic out;
    logic hlt;
  } ctrl_t;

  // {alu_sel[2:0], alu_cin} encodings, passed through from imm unchanged
  localparam logic [3:0] ALU_ADD_AB = 4'b000_0;
  localparam logic [3:0] ALU_ADC_AB = 4'b000_1;
  localparam logic [3:0] ALU_SUB_AB = 4'b001_1;
  localparam logic [3:0] ALU_AND_AB = 4'b010_0;
  localparam logic [3:0] ALU_OR_AB  = 4'b011_0;
  localparam logic [3:0] ALU_XOR_AB = 4'b100_0;

  function automatic logic [OP_W-1:0] op_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OP_W];
  endfunction

  function automatic logic [DATA_W-1:0] imm_of(input logic [INSTR_W-1:0] instr);
    return instr[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_idecode.sv
// Combinational instruction decoder: opcode -> one-hot control bundle.
//   op     : opcode nibble of the instruction being decoded
//   ctrl_c : one-hot controls; all zero for NOP and unassigned opcodes
module cpu_ctrl_fsm_idecode
  import cpu_ctrl_fsm_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output ctrl_t           ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    case (op)
      OP_LDA:  ctrl_c.lda  = 1'b1;
      OP_LDB:  ctrl_c.ldb  = 1'b1;
      OP_ALU:  ctrl_c.alu  = 1'b1;
      OP_MOVB: ctrl_c.movb = 1'b1;
      OP_JMP:  ctrl_c.jmp  = 1'b1;
      OP_JZ:   ctrl_c.jz   = 1'b1;
      OP_JC:   ctrl_c.jc   = 1'b1;
      OP_OUT:  ctrl_c.out  = 1'b1;
      OP_HLT:  ctrl_c.hlt  = 1'b1;
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 4-bit CPU. Fetches from a registered
// ROM, decodes, issues operands to the registered ALU (reg_alu4) and writes
// its result back into A / C / Z. Also owns PC, B, branches, a valid/ready
// output port and HALT.
//   clk, rst            : clock, asynchronous active-low reset
//   run                 : allows the sequencer to leave S_FETCH
//   imem_addr/imem_data : ROM address (= pc) and instruction returned 1 cycle later
//   alu_a/b/sel/cin     : registered ALU operands, held until the next ALU op
//   alu_out/alu_cout    : registered ALU result
//   out_data/valid/ready: output port handshake
//   acc, flag_c, flag_z, pc, halted : architectural state (debug)
module cpu_ctrl_fsm
  import cpu_ctrl_fsm_pkg::*;
#(
  parameter int unsigned PC_W     = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic [PC_W-1:0]       imem_addr,
  input  logic [INSTR_W-1:0]    imem_data,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [2:0]            alu_sel,
  output logic                  alu_cin,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic                  alu_cout,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     acc,
  output logic                  flag_c,
  output logic                  flag_z,
  output logic [PC_W-1:0]       pc,
  output logic                  halted
);

  state_t              state;
  logic [DATA_W-1:0]   b_reg;
  ctrl_t               dec_c;
  logic [DATA_W-1:0]   imm_c;
  logic [PC_W-1:0]     pc_inc_c;
  logic [PC_W-1:0]     pc_imm_c;

  // ROM address is the PC itself; the ROM registers it during S_FETCH
  assign imem_addr = pc;

  assign imm_c    = imm_of(imem_data);
  assign pc_inc_c = pc + PC_W'(1);
  assign pc_imm_c = PC_W'(imm_c);

  cpu_ctrl_fsm_idecode u_idecode (
    .op     (op_of(imem_data)),
    .ctrl_c (dec_c)
  );

  // Sequencer and architectural registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      pc        <= PC_W'(RESET_PC);
      acc       <= '0;
      b_reg     <= '0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      alu_cin   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (run) state <= S_DECODE;
        end

        // imem_data now holds the instruction addressed during S_FETCH
        S_DECODE: begin
          state <= S_FETCH;
          pc    <= pc_inc_c;
          if (dec_c.lda) begin
            acc    <= imm_c;
            flag_z <= (imm_c == '0);
          end
          if (dec_c.ldb)  b_reg <= imm_c;
          if (dec_c.movb) b_reg <= acc;
          if (dec_c.alu) begin
            alu_a              <= acc;
            alu_b              <= b_reg;
            {alu_sel, alu_cin} <= imm_c;
            state              <= S_EXEC;
          end
          if (dec_c.jmp)           pc <= pc_imm_c;
          if (dec_c.jz && flag_z)  pc <= pc_imm_c;
          if (dec_c.jc && flag_c)  pc <= pc_imm_c;
          if (dec_c.out) begin
            out_data  <= acc;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
          if (dec_c.hlt) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end
        end

        // ALU captures the held operands at this edge
        S_EXEC: state <= S_WB;

        S_WB: begin
          acc    <= alu_out;
          flag_c <= alu_cout;
          flag_z <= (alu_out == '0);
          state  <= S_FETCH;
        end

        // out_valid is registered, so a transfer needs valid already high
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_FETCH;
          end
        end

        S_HALT: state <= S_HALT;

        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm paired with a registered 4-bit ALU model
// and a 16x8 registered ROM model.
module tb_cpu_ctrl_fsm;
  import cpu_ctrl_fsm_pkg::*;

  logic       clk;
  logic       rst;
  logic       run;
  logic [3:0] imem_addr;
  logic [7:0] imem_data;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic       alu_cin;
  logic [3:0] alu_out;
  logic       alu_cout;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] acc;
  logic       flag_c;
  logic       flag_z;
  logic [3:0] pc;
  logic       halted;

  int tests;
  int fails;

  logic [7:0] rom [16];

  cpu_ctrl_fsm #(.PC_W(4), .RESET_PC(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_cin   (alu_cin),
    .alu_out   (alu_out),
    .alu_cout  (alu_cout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .pc        (pc),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM
  always @(posedge clk) imem_data <= rom[imem_addr];

  // Registered ALU model (reg_alu4 stand-in)
  always @(posedge clk) begin
    case (alu_sel)
      3'd0: {alu_cout, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_cin);
      3'd1: {alu_cout, alu_out} <= {1'b0, alu_a} + {1'b0, ~alu_b} + 5'(alu_cin);
      3'd2: {alu_cout, alu_out} <= {1'b0, alu_a & alu_b};
      3'd3: {alu_cout, alu_out} <= {1'b0, alu_a | alu_b};
      3'd4: {alu_cout, alu_out} <= {1'b0, alu_a ^ alu_b};
      default: {alu_cout, alu_out} <= {1'b0, alu_a};
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic apply_reset(input logic run_after);
    rst = 1'b0;
    run = 1'b0;
    out_ready = 1'b0;
    step(2);
    rst = 1'b1;
    run = run_after;
  endtask

  task automatic test_run_gate();
    clear_rom();
    rom[0] = 8'h17;
    apply_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      tests++; if (pc !== 4'h0 || imem_addr !== 4'h0) begin fails++; $display("FAIL run_gate_pc: got pc=%h addr=%h expected 0", pc, imem_addr); end
      tests++; if (acc !== 4'h0) begin fails++; $display("FAIL run_gate_acc: got %h expected 0", acc); end
    end
    run = 1'b1;
    step(2);
    tests++; if (acc !== 4'h7) begin fails++; $display("FAIL run_go_acc: got %h expected 7", acc); end
    tests++; if (pc !== 4'h1) begin fails++; $display("FAIL run_go_pc: got %h expected 1", pc); end
  endtask

  task automatic test_alu_add();
    clear_rom();
    rom[0] = 8'h13; rom[1] = 8'h25; rom[2] = {4'h3, ALU_ADD_AB};
    apply_reset(1'b1);
    step(2);
    tests++; if (acc !== 4'h3 || pc !== 4'h1) begin fails++; $display("FAIL lda: got acc=%h pc=%h expected 3/1", acc, pc); end
    step(4);
    tests++; if ({alu_a, alu_b, alu_sel, alu_cin} !== {4'h3, 4'h5, ALU_ADD_AB}) begin fails++; $display("FAIL alu_issue: got %h expected %h", {alu_a, alu_b, alu_sel, alu_cin}, {4'h3, 4'h5, ALU_ADD_AB}); end
    tests++; if (pc !== 4'h3) begin fails++; $display("FAIL alu_pc: got %h expected 3", pc); end
    step(1);
    tests++; if (acc !== 4'h3) begin fails++; $display("FAIL alu_exec_acc: got %h expected 3", acc); end
    step(1);
    tests++; if (acc !== 4'h8 || flag_c !== 1'b0 || flag_z !== 1'b0) begin fails++; $display("FAIL alu_wb: got acc=%h c=%b z=%b expected 8/0/0", acc, flag_c, flag_z); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    run = 1'b1;
    #1;
    tests++; if (acc !== 4'h0 || flag_c !== 1'b0 || flag_z !== 1'b0) begin fails++; $display("FAIL reset_acc_flags: got acc=%h c=%b z=%b expected 0", acc, flag_c, flag_z); end
    tests++; if (pc !== 4'h0 || imem_addr !== 4'h0) begin fails++; $display("FAIL reset_pc: got pc=%h addr=%h expected 0", pc, imem_addr); end
    tests++; if ({alu_a, alu_b, alu_sel, alu_cin} !== 12'h000) begin fails++; $display("FAIL reset_alu: got %h expected 000", {alu_a, alu_b, alu_sel, alu_cin}); end
    tests++; if (out_valid !== 1'b0 || out_data !== 4'h0 || halted !== 1'b0) begin fails++; $display("FAIL reset_out: got v=%b d=%h h=%b expected 0", out_valid, out_data, halted); end
    step(3);
    tests++; if (pc !== 4'h0 || acc !== 4'h0) begin fails++; $display("FAIL reset_hold: got pc=%h acc=%h expected 0", pc, acc); end
  endtask

  task automatic test_carry_branch();
    clear_rom();
    rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = {4'h3, ALU_ADD_AB}; rom[3] = 8'h79;
    rom[9] = 8'h6C;
    apply_reset(1'b1);
    step(8);
    tests++; if (acc !== 4'h0 || flag_c !== 1'b1 || flag_z !== 1'b1) begin fails++; $display("FAIL carry_wb: got acc=%h c=%b z=%b expected 0/1/1", acc, flag_c, flag_z); end
    step(2);
    tests++; if (pc !== 4'h9) begin fails++; $display("FAIL jc_taken: got %h expected 9", pc); end
    step(2);
    tests++; if (pc !== 4'hC) begin fails++; $display("FAIL jz_taken: got %h expected c", pc); end
  endtask

  task automatic test_carry_fallthrough();
    clear_rom();
    rom[0] = 8'h1F; rom[1] = 8'h20; rom[2] = {4'h3, ALU_ADD_AB}; rom[3] = 8'h79;
    apply_reset(1'b1);
    step(10);
    tests++; if (acc !== 4'hF || flag_c !== 1'b0 || flag_z !== 1'b0) begin fails++; $display("FAIL nocarry_wb: got acc=%h c=%b z=%b expected f/0/0", acc, flag_c, flag_z); end
    tests++; if (pc !== 4'h4) begin fails++; $display("FAIL jc_not_taken: got %h expected 4", pc); end
  endtask

  task automatic test_out_wait();
    int xfers;
    int vcycles;
    clear_rom();
    rom[0] = 8'h16; rom[1] = 8'h80;
    apply_reset(1'b1);
    xfers = 0;
    vcycles = 0;
    step(4);
    tests++; if (out_valid !== 1'b1 || out_data !== 4'h6 || pc !== 4'h2) begin fails++; $display("FAIL out_rise: got v=%b d=%h pc=%h expected 1/6/2", out_valid, out_data, pc); end
    for (int i = 0; i < 3; i++) begin
      if (out_valid) vcycles++;
      if (out_valid && out_ready) xfers++;
      step(1);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL out_hold: got %b expected 1", out_valid); end
    end
    out_ready = 1'b1;
    if (out_valid) vcycles++;
    if (out_valid && out_ready) xfers++;
    step(1);
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL out_drop: got %b expected 0", out_valid); end
    tests++; if (xfers !== 1 || vcycles !== 4) begin fails++; $display("FAIL out_count: got xfers=%0d vcycles=%0d expected 1/4", xfers, vcycles); end
  endtask

  task automatic test_out_ready_early();
    int xfers;
    clear_rom();
    rom[0] = 8'h19; rom[1] = 8'h80;
    apply_reset(1'b1);
    out_ready = 1'b1;
    xfers = 0;
    step(3);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL early_pre: got %b expected 0", out_valid); end
    if (out_valid && out_ready) xfers++;
    step(1);
    tests++; if (out_valid !== 1'b1 || out_data !== 4'h9) begin fails++; $display("FAIL early_rise: got v=%b d=%h expected 1/9", out_valid, out_data); end
    if (out_valid && out_ready) xfers++;
    step(1);
    tests++; if (out_valid !== 1'b0 || xfers !== 1) begin fails++; $display("FAIL early_xfer: got v=%b xfers=%0d expected 0/1", out_valid, xfers); end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap_halt();
    clear_rom();
    rom[0] = 8'h63; rom[1] = 8'h10; rom[2] = 8'h5F; rom[3] = 8'hF0; rom[15] = 8'h00;
    apply_reset(1'b1);
    step(2);
    tests++; if (pc !== 4'h1) begin fails++; $display("FAIL jz_not_taken: got %h expected 1", pc); end
    step(4);
    tests++; if (pc !== 4'hF || flag_z !== 1'b1) begin fails++; $display("FAIL jmp_f: got pc=%h z=%b expected f/1", pc, flag_z); end
    step(2);
    tests++; if (pc !== 4'h0) begin fails++; $display("FAIL pc_wrap: got %h expected 0", pc); end
    step(2);
    tests++; if (pc !== 4'h3) begin fails++; $display("FAIL jz_wrap: got %h expected 3", pc); end
    step(2);
    tests++; if (halted !== 1'b1 || pc !== 4'h4) begin fails++; $display("FAIL halt: got h=%b pc=%h expected 1/4", halted, pc); end
    for (int i = 0; i < 6; i++) begin
      run = ~run;
      step(1);
      tests++; if (halted !== 1'b1 || pc !== 4'h4 || acc !== 4'h0) begin fails++; $display("FAIL halt_frozen: got h=%b pc=%h acc=%h expected 1/4/0", halted, pc, acc); end
    end
  endtask

  task automatic test_reset_mid_exec();
    clear_rom();
    rom[0] = 8'h13; rom[1] = 8'h25; rom[2] = {4'h3, ALU_ADD_AB};
    apply_reset(1'b1);
    step(6);
    tests++; if (alu_a !== 4'h3 || acc !== 4'h3) begin fails++; $display("FAIL mid_exec_setup: got alu_a=%h acc=%h expected 3/3", alu_a, acc); end
    rst = 1'b0;
    #1;
    tests++; if (acc !== 4'h0 || pc !== 4'h0 || alu_a !== 4'h0 || flag_c !== 1'b0 || flag_z !== 1'b0) begin fails++; $display("FAIL mid_exec_abort: got acc=%h pc=%h a=%h c=%b z=%b expected 0", acc, pc, alu_a, flag_c, flag_z); end
    step(2);
    rst = 1'b1;
    run = 1'b0;
    step(3);
    tests++; if (acc !== 4'h0 || pc !== 4'h0 || flag_c !== 1'b0 || flag_z !== 1'b0) begin fails++; $display("FAIL mid_exec_nowb: got acc=%h pc=%h c=%b z=%b expected 0", acc, pc, flag_c, flag_z); end
    run = 1'b1;
    step(2);
    tests++; if (acc !== 4'h3 || pc !== 4'h1) begin fails++; $display("FAIL mid_exec_restart: got acc=%h pc=%h expected 3/1", acc, pc); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    run = 1'b0;
    out_ready = 1'b0;
    clear_rom();
    test_run_gate();
    test_alu_add();
    test_reset();
    test_carry_branch();
    test_carry_fallthrough();
    test_out_wait();
    test_out_ready_early();
    test_wrap_halt();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
